// File: rtl/nn_pkg.sv
// Shared helpers for the neuron datapath: saturation limits, rounding shift
// and the handshake-mode selector strings.
package nn_pkg;

  localparam string BURST_YES = "yes";
  localparam string BURST_NO  = "no";

  // Largest positive value representable in a signed field of the given width.
  function automatic int sat_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  // Arithmetic right shift with round-half-up; a shift of zero passes through.
  function automatic longint round_shift(input longint x, input int shift);
    if (shift <= 0) return x;
    return (x + (longint'(1) <<< (shift - 1))) >>> shift;
  endfunction

endpackage

// File: rtl/relu_round_sat.sv
// Combinational second-stage datapath: ReLU, rounding rescale, then clamp to
// the positive range of the activation width.
module relu_round_sat
  import nn_pkg::*;
#(
  parameter int WIDTH_S   = 12,
  parameter int SHIFT     = 3,
  parameter int WIDTH_OUT = 8
) (
  input  logic signed [WIDTH_S-1:0]   sum,
  output logic signed [WIDTH_OUT-1:0] act
);

  localparam longint SAT = longint'(sat_max(WIDTH_OUT));

  longint relu_val;
  longint scaled;

  // The ReLU output is never negative, so only the upper clamp is needed.
  always_comb begin
    relu_val = sum[WIDTH_S-1] ? 64'sd0 : longint'(sum);
    scaled   = round_shift(relu_val, SHIFT);
    act      = (scaled > SAT) ? WIDTH_OUT'(SAT) : WIDTH_OUT'(scaled);
  end

endmodule

// File: rtl/bias_activation.sv
// Per-neuron bias add, ReLU, rounding rescale and saturation in a two-stage
// valid/ready pipeline feeding the next layer's input broadcast.
module bias_activation
  import nn_pkg::*;
#(
  parameter int    WIDTH_IN  = 11,
  parameter int    WIDTH_B   = 8,
  parameter int    WIDTH_OUT = 8,
  parameter int    SHIFT     = 3,
  parameter string BURST     = "yes"
) (
  input  logic                        iCLK,
  input  logic                        iRST,
  input  logic                        iValid_AS,
  output logic                        oReady_AS,
  input  logic signed [WIDTH_IN-1:0]  iData_AS,
  input  logic                        iValid_AB,
  output logic                        oReady_AB,
  input  logic signed [WIDTH_B-1:0]   iData_AB,
  output logic                        oValid_BM,
  input  logic                        iReady_BM,
  output logic signed [WIDTH_OUT-1:0] oData_BM
);

  localparam int WIDTH_S    = ((WIDTH_IN > WIDTH_B) ? WIDTH_IN : WIDTH_B) + 1;
  localparam bit BURST_MODE = (BURST == BURST_YES);

  logic                        run;
  logic signed [WIDTH_B-1:0]   bias;
  logic                        vld_p1;
  logic                        vld_p2;
  logic                        rdy_as_q;
  logic signed [WIDTH_S-1:0]   sum_p1;
  logic signed [WIDTH_OUT-1:0] act_p2;
  logic signed [WIDTH_OUT-1:0] act_nxt;

  logic rdy2;
  logic rdy_as;
  logic acc;
  logic adv;
  logic vld_p1_nxt;
  logic vld_p2_nxt;

  // Burst mode lets a stage refill in the cycle it empties; otherwise each
  // stage only loads while its own valid flag is clear.
  always_comb begin
    if (BURST_MODE) begin
      rdy2   = !vld_p2 || iReady_BM;
      rdy_as = run && (!vld_p1 || rdy2);
    end else begin
      rdy2   = !vld_p2;
      rdy_as = rdy_as_q;
    end
    acc        = iValid_AS && rdy_as;
    adv        = vld_p1 && rdy2;
    vld_p1_nxt = acc || (vld_p1 && !adv);
    vld_p2_nxt = adv || (vld_p2 && !iReady_BM);
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      run      <= 1'b0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      rdy_as_q <= 1'b0;
      bias     <= '0;
      act_p2   <= '0;
    end else begin
      run      <= 1'b1;
      vld_p1   <= vld_p1_nxt;
      vld_p2   <= vld_p2_nxt;
      rdy_as_q <= !vld_p1_nxt;
      if (iValid_AB && run) bias <= iData_AB;
      if (adv) act_p2 <= act_nxt;
    end
  end

  // Stage 1: bias add; a same-cycle bias write is seen only by later sums.
  always_ff @(posedge iCLK) begin
    if (acc) sum_p1 <= WIDTH_S'(iData_AS) + WIDTH_S'(bias);
  end

  // Stage 2: activation computed from stage-1 contents, registered on advance.
  relu_round_sat #(
    .WIDTH_S  (WIDTH_S),
    .SHIFT    (SHIFT),
    .WIDTH_OUT(WIDTH_OUT)
  ) u_stage2 (
    .sum(sum_p1),
    .act(act_nxt)
  );

  assign oReady_AS = rdy_as;
  assign oReady_AB = run;
  assign oValid_BM = vld_p2;
  assign oData_BM  = act_p2;

endmodule

// File: tb/tb_bias_activation.sv
// Directed bench for bias_activation: one burst-mode and one half-rate instance.
module tb_bias_activation;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic              valid_as = 1'b0;
  logic              ready_as;
  logic signed [10:0] data_as = '0;
  logic              valid_ab = 1'b0;
  logic              ready_ab;
  logic signed [7:0] data_ab = '0;
  logic              valid_bm;
  logic              ready_bm = 1'b1;
  logic signed [7:0] data_bm;

  logic              nb_valid_as = 1'b0;
  logic              nb_ready_as;
  logic signed [10:0] nb_data_as = '0;
  logic              nb_valid_ab = 1'b0;
  logic              nb_ready_ab;
  logic signed [7:0] nb_data_ab = '0;
  logic              nb_valid_bm;
  logic              nb_ready_bm = 1'b1;
  logic signed [7:0] nb_data_bm;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bias_activation #(.BURST("yes")) dut (
    .iCLK(clk), .iRST(rst_n),
    .iValid_AS(valid_as), .oReady_AS(ready_as), .iData_AS(data_as),
    .iValid_AB(valid_ab), .oReady_AB(ready_ab), .iData_AB(data_ab),
    .oValid_BM(valid_bm), .iReady_BM(ready_bm), .oData_BM(data_bm)
  );

  bias_activation #(.BURST("no")) dut_nb (
    .iCLK(clk), .iRST(rst_n),
    .iValid_AS(nb_valid_as), .oReady_AS(nb_ready_as), .iData_AS(nb_data_as),
    .iValid_AB(nb_valid_ab), .oReady_AB(nb_ready_ab), .iData_AB(nb_data_ab),
    .oValid_BM(nb_valid_bm), .iReady_BM(nb_ready_bm), .oData_BM(nb_data_bm)
  );

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic write_bias(input logic signed [7:0] b);
    valid_ab = 1'b1;
    data_ab  = b;
    #1;
    checks++;
    if (ready_ab !== 1'b1) begin
      errors++;
      $display("FAIL bias_ready: got %b expected 1", ready_ab);
    end
    tick();
    valid_ab = 1'b0;
  endtask

  task automatic run_single(input logic signed [10:0] sum, input logic signed [7:0] exp,
                            input string name);
    ready_bm = 1'b1;
    valid_as = 1'b1;
    data_as  = sum;
    #1;
    checks++;
    if (ready_as !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_as: got %b expected 1", name, ready_as);
    end
    tick();
    valid_as = 1'b0;
    #1;
    checks++;
    if (valid_bm !== 1'b0) begin
      errors++;
      $display("FAIL %s early_valid: got %b expected 0", name, valid_bm);
    end
    tick();
    checks++;
    if (valid_bm !== 1'b1 || data_bm !== exp) begin
      errors++;
      $display("FAIL %s result: got valid=%b data=%0d expected valid=1 data=%0d",
               name, valid_bm, data_bm, exp);
    end
    tick();
    checks++;
    if (valid_bm !== 1'b0) begin
      errors++;
      $display("FAIL %s drained: got valid=%b expected 0", name, valid_bm);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (valid_bm !== 1'b0 || data_bm !== 8'sd0 || ready_as !== 1'b0 || ready_ab !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b data=%0d rdy_as=%b rdy_ab=%b expected 0 0 0 0",
               valid_bm, data_bm, ready_as, ready_ab);
    end
    checks++;
    if (nb_valid_bm !== 1'b0 || nb_ready_as !== 1'b0 || nb_ready_ab !== 1'b0) begin
      errors++;
      $display("FAIL reset_state_nb: got valid=%b rdy_as=%b rdy_ab=%b expected 0 0 0",
               nb_valid_bm, nb_ready_as, nb_ready_ab);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (ready_ab !== 1'b1 || ready_as !== 1'b1 || nb_ready_as !== 1'b1) begin
      errors++;
      $display("FAIL after_reset: got rdy_ab=%b rdy_as=%b nb_rdy_as=%b expected 1 1 1",
               ready_ab, ready_as, nb_ready_as);
    end
  endtask

  task automatic test_basic;
    write_bias(8'sd5);
    run_single(11'sd20, 8'sd3, "basic_20");
  endtask

  task automatic test_neg_bias;
    write_bias(-8'sd8);
    run_single(-11'sd100, 8'sd0, "neg_m100");
    run_single(11'sd7, 8'sd0, "neg_7");
    run_single(11'sd8, 8'sd0, "neg_8");
    run_single(11'sd11, 8'sd0, "neg_11");
    run_single(11'sd20, 8'sd2, "neg_20");
  endtask

  task automatic test_saturation;
    write_bias(8'sd127);
    run_single(11'sd1023, 8'sd127, "sat_hi");
    run_single(-11'sd1024, 8'sd0, "sat_lo");
  endtask

  task automatic test_same_cycle_bias;
    write_bias(8'sd0);
    ready_bm = 1'b1;
    valid_ab = 1'b1;
    data_ab  = 8'sd100;
    valid_as = 1'b1;
    data_as  = 11'sd40;
    tick();
    valid_ab = 1'b0;
    valid_as = 1'b0;
    tick();
    checks++;
    if (valid_bm !== 1'b1 || data_bm !== 8'sd5) begin
      errors++;
      $display("FAIL same_cycle_old_bias: got valid=%b data=%0d expected valid=1 data=5",
               valid_bm, data_bm);
    end
    tick();
    run_single(11'sd40, 8'sd18, "same_cycle_new_bias");
  endtask

  task automatic test_back_to_back;
    int in_idx = 0;
    int out_idx = 0;
    int stalls = 0;
    logic prev_stall = 1'b0;
    logic signed [7:0] prev_data = '0;
    write_bias(8'sd0);
    for (int c = 0; c < 80 && out_idx < 10; c++) begin
      valid_as = (in_idx < 10);
      data_as  = 11'(in_idx * 8);
      ready_bm = (c % 2 == 0);
      #1;
      if (prev_stall) begin
        checks++;
        if (valid_bm !== 1'b1 || data_bm !== prev_data) begin
          errors++;
          $display("FAIL bp_hold: got valid=%b data=%0d expected valid=1 data=%0d",
                   valid_bm, data_bm, prev_data);
        end
      end
      if (!ready_as) begin
        stalls++;
        checks++;
        if (!(valid_bm && !ready_bm)) begin
          errors++;
          $display("FAIL bp_ready_drop: got rdy_as=0 with valid=%b ready_bm=%b expected 1 0",
                   valid_bm, ready_bm);
        end
      end
      if (ready_bm) begin
        checks++;
        if (ready_as !== 1'b1) begin
          errors++;
          $display("FAIL bp_ready_up: got rdy_as=%b expected 1", ready_as);
        end
      end
      if (valid_bm && ready_bm) begin
        checks++;
        if (data_bm !== 8'(out_idx)) begin
          errors++;
          $display("FAIL bp_order: got %0d expected %0d", data_bm, out_idx);
        end
        out_idx++;
      end
      if (valid_as && ready_as) in_idx++;
      prev_stall = valid_bm && !ready_bm;
      prev_data  = data_bm;
      tick();
    end
    valid_as = 1'b0;
    ready_bm = 1'b1;
    checks++;
    if (out_idx != 10 || stalls == 0) begin
      errors++;
      $display("FAIL bp_count: got outputs=%0d stalls=%0d expected outputs=10 stalls>0",
               out_idx, stalls);
    end
    tick();
    tick();
  endtask

  task automatic test_throughput;
    int accepted = 0;
    int out_idx = 0;
    ready_bm = 1'b1;
    for (int c = 0; c < 13; c++) begin
      valid_as = (c < 10);
      data_as  = 11'(c * 8);
      #1;
      if (valid_as && ready_as) accepted++;
      if (valid_bm) begin
        checks++;
        if (data_bm !== 8'(out_idx)) begin
          errors++;
          $display("FAIL thru_order: got %0d expected %0d", data_bm, out_idx);
        end
        out_idx++;
      end
      tick();
    end
    valid_as = 1'b0;
    checks++;
    if (accepted != 10 || out_idx != 10) begin
      errors++;
      $display("FAIL thru_rate: got accepted=%0d outputs=%0d in 13 cycles expected 10 10",
               accepted, out_idx);
    end
  endtask

  task automatic test_burst_no;
    int in_idx = 0;
    int out_idx = 0;
    int first_acc = -1;
    int last_acc = -1;
    logic prev_rdy = 1'b0;
    nb_ready_bm = 1'b1;
    for (int c = 0; c < 60 && out_idx < 10; c++) begin
      nb_valid_as = (in_idx < 10);
      nb_data_as  = 11'(in_idx * 8);
      #1;
      if (nb_valid_as && c > 0) begin
        checks++;
        if (nb_ready_as === prev_rdy) begin
          errors++;
          $display("FAIL nb_alternate: cycle %0d got rdy_as=%b expected %b", c, nb_ready_as,
                   !prev_rdy);
        end
      end
      prev_rdy = nb_ready_as;
      if (nb_valid_bm) begin
        checks++;
        if (nb_data_bm !== 8'(out_idx)) begin
          errors++;
          $display("FAIL nb_order: got %0d expected %0d", nb_data_bm, out_idx);
        end
        out_idx++;
      end
      if (nb_valid_as && nb_ready_as) begin
        if (first_acc < 0) first_acc = c;
        last_acc = c;
        in_idx++;
      end
      tick();
    end
    nb_valid_as = 1'b0;
    checks++;
    if (out_idx != 10 || (last_acc - first_acc) != 18) begin
      errors++;
      $display("FAIL nb_rate: got outputs=%0d accept_span=%0d expected 10 18",
               out_idx, last_acc - first_acc);
    end
  endtask

  task automatic test_reset_inflight;
    write_bias(8'sd50);
    ready_bm = 1'b0;
    valid_as = 1'b1;
    data_as  = 11'sd100;
    tick();
    data_as = 11'sd200;
    tick();
    valid_as = 1'b0;
    #1;
    checks++;
    if (valid_bm !== 1'b1 || ready_as !== 1'b0) begin
      errors++;
      $display("FAIL full_pipe: got valid=%b rdy_as=%b expected 1 0", valid_bm, ready_as);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid_bm !== 1'b0 || data_bm !== 8'sd0 || ready_as !== 1'b0 || ready_ab !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b data=%0d rdy_as=%b rdy_ab=%b expected 0 0 0 0",
               valid_bm, data_bm, ready_as, ready_ab);
    end
    ready_bm = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (valid_bm !== 1'b0) begin
        errors++;
        $display("FAIL ghost_beat: cycle %0d got valid=%b expected 0", c, valid_bm);
      end
    end
    run_single(11'sd16, 8'sd2, "post_reset_bias0");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_neg_bias();
    test_saturation();
    test_same_cycle_bias();
    test_back_to_back();
    test_throughput();
    test_burst_no();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
